uart_tx_ctrl: RTL

UART transmit controller: accepts a parallel byte on a valid strobe and serialises it as a start bit, LSB-first data bits, an optional parity bit and a stop bit on `TX_OUT`, one bit per `CLK` cycle. It sits directly downstream of the parity calculator. Both blocks see the same `P_DATA`/`Data_Valid`. This block consumes the calculator's registered `Par_Bit` and owns all frame sequencing and the line output. Bit-rate division is done upstream by clock gating/prescaling, so one `CLK` edge equals one UART bit.

---
 rtl/uart_tx_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: serialises a parallel word as start, LSB-first data,
// optional parity and stop bits, one bit per CLK edge.
module uart_tx_ctrl #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  Par_Bit,
   output logic                  TX_OUT,
   output logic                  Busy
);

   localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } state_e;

   state_e                state_q;
   logic [CntW-1:0]       cnt_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic                  par_q;
   logic                  par_en_q;
   logic                  tx_q;
   logic                  busy_q;
   logic                  accept;
   logic                  last_bit;

   // New frames are only taken when the line is idle or showing a stop bit.
   assign accept   = Data_Valid && ((state_q == StIdle) || (state_q == StStop));
   assign last_bit = (cnt_q == CntW'(DATA_WIDTH));

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         par_en_q <= 1'b0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
      end else if (accept) begin
         state_q  <= StStart;
         cnt_q    <= '0;
         shift_q  <= P_DATA;
         par_en_q <= PAR_EN;
         tx_q     <= 1'b0;
         busy_q   <= 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
            end
            StStart: begin
               // Parity calculator output is stable from here; freeze it for the frame.
               par_q   <= Par_Bit;
               tx_q    <= shift_q[0];
               shift_q <= shift_q >> 1;
               cnt_q   <= CntW'(1);
               state_q <= StData;
            end
            StData: begin
               if (last_bit) begin
                  if (par_en_q) begin
                     tx_q    <= par_q;
                     state_q <= StParity;
                  end else begin
                     tx_q    <= 1'b1;
                     state_q <= StStop;
                  end
               end else begin
                  tx_q    <= shift_q[0];
                  shift_q <= shift_q >> 1;
                  cnt_q   <= cnt_q + CntW'(1);
               end
            end
            StParity: begin
               tx_q    <= 1'b1;
               state_q <= StStop;
            end
            StStop: begin
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign TX_OUT = tx_q;
   assign Busy   = busy_q;

endmodule
